// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a length-prefixed byte frame, writes
// big-endian words to consecutive addresses and releases the core on a good checksum.
module imem_loader #(
    parameter int WL = 32,
    parameter int AW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [WL-1:0] im_wdata,
    output logic          cpu_rst_n,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam int unsigned DEPTH = 1 << AW;

    logic [2:0]    state;
    logic [7:0]    len_hi;
    logic [16:0]   remaining;
    logic [AW:0]   word_addr;
    logic [1:0]    byte_cnt;
    logic [WL-9:0] asm_word;
    logic [7:0]    xor_acc;
    logic [15:0]   len_word;
    logic          xfer;

    assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CSUM);
    assign xfer     = in_valid && in_ready;
    assign len_word = {len_hi, in_data};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            len_hi    <= '0;
            remaining <= '0;
            word_addr <= '0;
            byte_cnt  <= '0;
            asm_word  <= '0;
            xor_acc   <= '0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            im_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state     <= S_LEN_HI;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        cpu_rst_n <= 1'b0;
                        xor_acc   <= '0;
                        word_addr <= '0;
                        byte_cnt  <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_hi <= in_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        remaining <= {1'b0, len_word};
                        if (32'(len_word) > DEPTH) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else if (len_word == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        asm_word <= {asm_word[WL-17:0], in_data};
                        xor_acc  <= xor_acc ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Address overflow cannot occur for a length that passed the
                            // LEN_LO check; treat it as a hard failure rather than wrap.
                            if (word_addr[AW]) begin
                                state <= S_ERR;
                                err   <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                im_we     <= 1'b1;
                                im_addr   <= word_addr[AW-1:0];
                                im_wdata  <= {asm_word, in_data};
                                word_addr <= word_addr + 1'b1;
                                remaining <= remaining - 17'd1;
                                if (remaining == 17'd1) begin
                                    state <= S_CSUM;
                                end
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        busy <= 1'b0;
                        if (in_data == xor_acc) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory the single-cycle core fetches from. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to consecutive word addresses starting at 0. It checks an XOR checksum and holds the core in reset until a load completes without error.

## Interface
- WL, 32: instruction word width; fixed at 4 bytes.
- AW, 8: instruction-memory word-address width; depth = 2^AW words.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte. A transfer occurs on a clock edge where in_valid && in_ready.
- im_we  out  1  instruction-memory write enable, one-cycle pulse.
- im_addr  out  AW  word address of the write.
- im_wdata  out  WL  word to write.
- cpu_rst_n  out  1  active-low reset to the core; low while the core must not run.
- busy  out  1  a load is in progress.
- done  out  1  last load completed and the checksum matched.
- err  out  1  last load failed.

## Operation
- Frame format, in byte order:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N words, 4 bytes each, MSB first.
  - CSUM: one byte, the XOR of all 4N payload bytes. The length bytes are not included.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- Transitions:
  - IDLE, DONE or ERR --start--> LEN_HI. On this transition: clear done and err, set busy, drive cpu_rst_n=0, reset the running XOR, word address and byte counter to 0.
  - LEN_HI --transfer--> LEN_LO.
  - LEN_LO --transfer-->:
    - ERR if N > 2^AW;
    - CSUM if N == 0;
    - DATA otherwise.
  - DATA: shift each accepted byte into a 32-bit assembly register, MSB first, and XOR it into the running checksum.
    - On the 4th byte: issue the write, increment the word address, decrement the remaining-word count.
    - After word N, go to CSUM.
  - CSUM --transfer-->:
    - DONE if the byte equals the running XOR: done=1, busy=0, cpu_rst_n=1.
    - ERR otherwise: err=1, busy=0, cpu_rst_n stays 0.
- in_ready = 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in IDLE, DONE and ERR. Bytes offered while in_ready=0 are not consumed.
- start is ignored in LEN_HI through CSUM.
- Address arithmetic: the word address is AW+1 bits internally. N == 2^AW is legal and fills memory exactly; no address wraps.
- Bytes from an aborted or failed load that were already written stay in memory. The loader does not roll them back.

## Timing
- Reset values of outputs: in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0. The state is IDLE, so the core stays in reset until the first successful load.
- Throughput: one byte per cycle, with no bubbles between words.
- Write latency: im_we, im_addr and im_wdata are registered and valid in the cycle after the edge that accepted a word's 4th byte. im_we is high for exactly that one cycle. Back-to-back words give an im_we pulse every 4 cycles.
- done or err, and cpu_rst_n, change in the cycle after the edge that accepted CSUM.
- When the 4th byte of the last word is accepted, the write of that word and the entry to CSUM happen together; the write still occurs.
- If RST is asserted mid-load, every register returns to its reset value immediately, with no clock needed. After release the loader is in IDLE.
- start arriving in the same cycle as a byte while in DONE or ERR: the byte is not consumed, because in_ready=0 in those states.

## Test plan
- After reset, all outputs at their reset values. Then start, followed by bytes 00 01 DE AD BE EF 22 -> one im_we with addr 0 and wdata 0xDEADBEEF; done=1 and cpu_rst_n=1 one cycle after the 0x22 byte.
- N=3, bytes streamed every cycle, checksum correct -> im_we pulses at addresses 0, 1, 2, spaced 4 cycles apart; in_ready never drops during the stream.
- Same frame with a bad checksum byte -> err=1, done=0, cpu_rst_n=0. All 3 words were still written.
- N=0: start, then 00 00 00 -> done=1 and no im_we. With N=2^AW+1 -> err=1 immediately after LEN_LO, and no im_we.
- Random gaps inserted in in_valid -> same writes and result as the gap-free case. A start pulse mid-frame is ignored.
- RST asserted after 6 bytes of an N=2 frame -> outputs return to reset values asynchronously. A new start and a full frame then complete with done=1.
